// File: rtl/yuv_scaler_pkg.sv
// Shared definitions for the YUV scaler source arbiter: FSM/grant encodings,
// default stream geometry and the round-robin pick helper.
package yuv_scaler_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 24;
  localparam int DEFAULT_LINES_PER_FRAME = 1080;

  // Grant one-hot constants (bit0 = s0, bit1 = s1)
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  // FSM states share the grant encoding so the state register drives grant directly
  localparam logic [1:0] ST_IDLE = GNT_NONE;
  localparam logic [1:0] ST_GNT0 = GNT_S0;
  localparam logic [1:0] ST_GNT1 = GNT_S1;

  // Source identifiers used for last_served
  localparam logic SRC_S0 = 1'b0;
  localparam logic SRC_S1 = 1'b1;

  // Pick the next grant state from the two SOF requests; ties go to the
  // source that was not served last.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                         input logic last_served);
    if (req0 && req1) return (last_served == SRC_S1) ? ST_GNT0 : ST_GNT1;
    if (req0) return ST_GNT0;
    if (req1) return ST_GNT1;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/yuv_frame_tracker.sv
// Line/frame counting and mid-frame SOF detection for the granted source.
// Reports frame completion to the arbiter FSM and keeps per-source frame counts.
module yuv_frame_tracker
  import yuv_scaler_pkg::*;
#(
  parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        active,
  input  logic        src_sel,
  input  logic        xfer,
  input  logic        beat_user,
  input  logic        beat_last,
  output logic        frame_done,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic        sof_err
);

  localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES_PER_FRAME - 1);

  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic           first_q, first_d;
  logic [15:0]    frm_cnt0_q, frm_cnt0_d;
  logic [15:0]    frm_cnt1_q, frm_cnt1_d;
  logic           sof_err_q, sof_err_d;
  logic           restart;
  logic [LCW-1:0] cur_line;

  // A tuser beat after the first beat of a grant restarts the frame count at line 0
  always_comb begin
    restart    = xfer & beat_user & ~first_q;
    cur_line   = restart ? '0 : line_cnt_q;
    frame_done = xfer & beat_last & (cur_line == LAST_LINE);

    line_cnt_d = line_cnt_q;
    first_d    = first_q;
    frm_cnt0_d = frm_cnt0_q;
    frm_cnt1_d = frm_cnt1_q;
    sof_err_d  = sof_err_q;

    if (!active) begin
      first_d = 1'b1;
    end else if (xfer) begin
      first_d = 1'b0;
    end

    if (restart) begin
      sof_err_d  = 1'b1;
      line_cnt_d = '0;
    end

    if (xfer && beat_last) begin
      line_cnt_d = frame_done ? '0 : (cur_line + LCW'(1));
    end

    if (frame_done) begin
      if (src_sel == SRC_S1) frm_cnt1_d = frm_cnt1_q + 16'd1;
      else                   frm_cnt0_d = frm_cnt0_q + 16'd1;
    end
  end

  // Counter and sticky-flag registers; reset abandons any partial frame
  always_ff @(posedge clk_in) begin
    if (reset) begin
      line_cnt_q <= '0;
      first_q    <= 1'b1;
      frm_cnt0_q <= 16'd0;
      frm_cnt1_q <= 16'd0;
      sof_err_q  <= 1'b0;
    end else begin
      line_cnt_q <= line_cnt_d;
      first_q    <= first_d;
      frm_cnt0_q <= frm_cnt0_d;
      frm_cnt1_q <= frm_cnt1_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign frm_cnt0 = frm_cnt0_q;
  assign frm_cnt1 = frm_cnt1_q;
  assign sof_err  = sof_err_q;

endmodule

// File: rtl/yuv_scaler_src_arb.sv
// Frame-granular round-robin arbiter sharing one YUV 2x scaler between two
// AXI-stream sources. Optional macro YUV_ARB_DROP_UNALIGNED_EN makes IDLE
// accept and discard non-SOF beats instead of stalling the source.
module yuv_scaler_src_arb
  import yuv_scaler_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  input  logic                  s0_tuser,
  input  logic                  s0_tlast,
  output logic                  s0_treadsy,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  input  logic                  s1_tuser,
  input  logic                  s1_tlast,
  output logic                  s1_treadsy,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tuser,
  output logic                  m_tlast,
  input  logic                  m_treadsy,
  output logic [1:0]            grant,
  output logic [15:0]           frm_cnt0,
  output logic [15:0]           frm_cnt1,
  output logic                  sof_err
);

  logic [1:0] state_q, state_d;
  logic       last_served_q, last_served_d;
  logic       req0, req1;
  logic       xfer;
  logic       frame_done;

  assign req0 = s0_tvalid & s0_tuser;
  assign req1 = s1_tvalid & s1_tuser;

  // Zero-latency stream mux toward the scaler, with ready routed back to the granted source
  always_comb begin
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tuser    = 1'b0;
    m_tlast    = 1'b0;
    s0_treadsy = 1'b0;
    s1_treadsy = 1'b0;
    case (state_q)
      ST_GNT0: begin
        m_tdata    = s0_tdata;
        m_tvalid   = s0_tvalid;
        m_tuser    = s0_tuser;
        m_tlast    = s0_tlast;
        s0_treadsy = m_treadsy;
      end
      ST_GNT1: begin
        m_tdata    = s1_tdata;
        m_tvalid   = s1_tvalid;
        m_tuser    = s1_tuser;
        m_tlast    = s1_tlast;
        s1_treadsy = m_treadsy;
      end
      default: begin
`ifdef YUV_ARB_DROP_UNALIGNED_EN
        s0_treadsy = s0_tvalid & ~s0_tuser;
        s1_treadsy = s1_tvalid & ~s1_tuser;
`else
        s0_treadsy = 1'b0;
        s1_treadsy = 1'b0;
`endif
      end
    endcase
    if (reset) begin
      m_tvalid   = 1'b0;
      s0_treadsy = 1'b0;
      s1_treadsy = 1'b0;
    end
  end

  assign xfer = m_tvalid & m_treadsy;

  // Arbitration FSM: grant on SOF request, release when the tracker reports frame end
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      ST_GNT0: begin
        if (frame_done) begin
          state_d       = ST_IDLE;
          last_served_d = SRC_S0;
        end
      end
      ST_GNT1: begin
        if (frame_done) begin
          state_d       = ST_IDLE;
          last_served_d = SRC_S1;
        end
      end
      default: begin
        state_d = rr_pick(req0, req1, last_served_q);
      end
    endcase
  end

  // State and round-robin history registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_served_q <= SRC_S1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  assign grant = state_q;

  yuv_frame_tracker #(
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_tracker (
    .clk_in    (clk_in),
    .reset     (reset),
    .active    (state_q != ST_IDLE),
    .src_sel   (state_q == ST_GNT1),
    .xfer      (xfer),
    .beat_user (m_tuser),
    .beat_last (m_tlast),
    .frame_done(frame_done),
    .frm_cnt0  (frm_cnt0),
    .frm_cnt1  (frm_cnt1),
    .sof_err   (sof_err)
  );

endmodule
